bram_dmem_master: RTL and testbench
===================================

BRAM_DMEM_MASTER -- requirements
Module: bram_dmem_master

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1096: number of 32-bit words on the attached BRAM port.
REQ-002 SHALL have clkb  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have rstb  input  1: asynchronous, active-high reset.
REQ-004 SHALL have req_valid input 1, req_ready output 1: request handshake; transfer occurs on a clkb edge with both high.
REQ-005 SHALL have req_we input 1 (1=store, 0=load), req_size input 2 (00 byte, 01 half, 10 word, 11 illegal), req_unsigned input 1 (zero-extend loads).
REQ-006 SHALL have req_addr input 32 (byte address) and req_wdata input 32 (store data, right-aligned).
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_rdata output 32 (extended load data, 0 for stores), rsp_err output 1.
REQ-008 SHALL have BRAM-side outputs enb 1, web 4, addrb 32, dinb 32, and inputs doutb 32, rstb_busy 1; BRAM read data appears on doutb one clkb edge after enb is sampled.

Function
REQ-009 SHALL implement states IDLE, ISSUE, DATA, RESP.
REQ-010 IDLE: req_ready = !rstb_busy; all other states: req_ready = 0.
REQ-011 On accept (edge E0), latch the request; if erroneous go to RESP with rsp_err=1, rsp_rdata=0, no BRAM access; else go to ISSUE.
REQ-012 Erroneous = req_size==11, or word index req_addr[31:2] >= MEM_DEPTH, or misalignment per REQ-021.
REQ-013 ISSUE (one cycle): enb=1, addrb={req_addr[31:2],2'b00}; loads web=0000, dinb=0; at E1 loads go to DATA, stores go to RESP.
REQ-014 Store lanes: byte web=0001<<addr[1:0], dinb={4{wdata[7:0]}}; half web=0011 (addr[1]=0) or 1100 (addr[1]=1), dinb={2{wdata[15:0]}}; word web=1111, dinb=wdata.
REQ-015 DATA (one cycle): enb=0; at E2 register rsp_rdata = doutb shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half), sign-extended unless req_unsigned; word passes unchanged; go to RESP.
REQ-016 Outside ISSUE: enb=0, web=0, dinb=0; addrb holds last value.
REQ-017 RESP: rsp_valid=1; rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-018 Latency from accept edge to first cycle of rsp_valid: load 2 edges, store 1 edge, error 0 edges (rsp_valid high in the cycle after accept).
REQ-019 rstb_busy rising while in ISSUE/DATA/RESP SHALL NOT abort the transaction; it only blocks the next accept.

Reset
REQ-020 While rstb high: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, enb=0, web=0, addrb=0, dinb=0; a reset mid-transaction drops it with no response; req_ready follows REQ-010 from the first cycle after rstb deasserts.

Configuration
REQ-021 Macro BRAM_DMEM_MASTER_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is erroneous (rsp_err=1, no BRAM access); undefined: no misalignment error, half uses addr[1] and ignores addr[0], word ignores addr[1:0].

Verification
REQ-022 Store word 0xDEADBEEF @0x10 (rsp_ready=1) -> ISSUE cycle enb=1, web=1111, addrb=0x10; rsp_valid 1 edge after accept, rsp_err=0; memory word 4 = 0xDEADBEEF.
REQ-023 Store byte 0x7F @0x13, then signed load byte @0x13 -> web=1000, dinb=0x7F7F7F7F; load rsp_rdata=0x0000007F 2 edges after accept; signed load half @0x12 after storing byte 0x80 @0x13 -> rsp_rdata=0xFFFF80xx per lane contents.
REQ-024 Unsigned load half @0x12 with word 0xBEEF1234 -> rsp_rdata=0x0000BEEF; signed -> 0xFFFFBEEF.
REQ-025 Load word @0x11 with macro defined -> rsp_err=1, enb never asserted; macro undefined -> normal load of word 4; any access @4*MEM_DEPTH -> rsp_err=1.
REQ-026 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rstb_busy=1 in IDLE -> req_ready=0, no accept.
REQ-027 Assert rstb during DATA -> all outputs 0 immediately, no rsp_valid after release, next request serviced normally.

Source files
------------

// File: rtl/bram_dmem_master.sv
// Single-outstanding load/store master driving one 32-bit BRAM port (byte-lane writes, 1-cycle read).
// Optional: define BRAM_DMEM_MASTER_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
`timescale 1ns/1ps
module bram_dmem_master #(
   parameter int unsigned MEM_DEPTH = 1096
) (
   input  logic        clkb,
   input  logic        rstb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        enb,
   output logic [3:0]  web,
   output logic [31:0] addrb,
   output logic [31:0] dinb,
   input  logic [31:0] doutb,
   input  logic        rstb_busy
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_RESP} state_t;
   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [31:0] DEPTH   = 32'(MEM_DEPTH);

   state_t      state_q;
   logic        we_q, uns_q;
   logic [1:0]  size_q, lane_q;
   logic        rsp_valid_q, rsp_err_q, enb_q;
   logic [3:0]  web_q;
   logic [31:0] addrb_q, dinb_q, rdata_q;

   logic        accept, req_err, misalign;
   logic [3:0]  web_d;
   logic [31:0] dinb_d, rdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Reset gating keeps req_ready low while rstb is held, even though state already reads IDLE.
   assign req_ready = (state_q == S_IDLE) && !rstb_busy && !rstb;
   assign accept    = req_valid && req_ready;

`ifdef BRAM_DMEM_MASTER_MISALIGN_CHECK_EN
   assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_err = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= DEPTH) || misalign;

   always_comb begin
      web_d  = '0;
      dinb_d = '0;
      if (req_we) begin
         case (req_size)
            SZ_BYTE: begin
               web_d  = 4'b0001 << req_addr[1:0];
               dinb_d = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
               web_d  = req_addr[1] ? 4'b1100 : 4'b0011;
               dinb_d = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
               web_d  = 4'b1111;
               dinb_d = req_wdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_sel = doutb[{lane_q, 3'b000} +: 8];
      half_sel = doutb[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_BYTE: rdata_d = {{24{!uns_q && byte_sel[7]}}, byte_sel};
         SZ_HALF: rdata_d = {{16{!uns_q && half_sel[15]}}, half_sel};
         default: rdata_d = doutb;
      endcase
   end

   always_ff @(posedge clkb or posedge rstb) begin
      if (rstb) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= '0;
         lane_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
         enb_q       <= 1'b0;
         web_q       <= '0;
         addrb_q     <= '0;
         dinb_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  lane_q  <= req_addr[1:0];
                  rdata_q <= '0;
                  if (req_err) begin
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     rsp_err_q <= 1'b0;
                     enb_q     <= 1'b1;
                     web_q     <= web_d;
                     dinb_q    <= dinb_d;
                     addrb_q   <= {req_addr[31:2], 2'b00};
                     state_q   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               enb_q  <= 1'b0;
               web_q  <= '0;
               dinb_q <= '0;
               if (we_q) begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               rdata_q     <= rdata_d;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_err_q;
   assign enb       = enb_q;
   assign web       = web_q;
   assign addrb     = addrb_q;
   assign dinb      = dinb_q;

endmodule

// File: tb/tb_bram_dmem_master.sv
// Self-checking bench for bram_dmem_master: fixed vector table, hand sequences, randomized traffic vs byte-array model.
`timescale 1ns/1ps
module tb_bram_dmem_master;
   localparam int unsigned DEPTH = 64;

   logic        clkb = 1'b0, rstb = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_ready = 1'b1, rstb_busy = 1'b0;
   logic        req_ready, rsp_valid, rsp_err, enb;
   logic [31:0] rsp_rdata, addrb, dinb;
   logic [3:0]  web;
   logic [31:0] doutb = '0;

   always #5 clkb = ~clkb;

   bram_dmem_master #(.MEM_DEPTH(DEPTH)) dut (
      .clkb(clkb), .rstb(rstb),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .rstb_busy(rstb_busy)
   );

   // BRAM port model: byte-lane write, read-first, data one edge after enb.
   logic [31:0] mem [DEPTH] = '{default: '0};
   always @(posedge clkb) begin
      if (enb && (addrb[31:2] < DEPTH)) begin
         for (int i = 0; i < 4; i++)
            if (web[i]) mem[addrb[31:2]][8*i +: 8] <= dinb[8*i +: 8];
         doutb <= mem[addrb[31:2]];
      end
   end

   int          enb_total = 0;
   logic [3:0]  cap_web = '0;
   logic [31:0] cap_addrb = '0, cap_dinb = '0;
   always @(posedge clkb) begin
      if (enb) begin
         enb_total <= enb_total + 1;
         cap_web   <= web;
         cap_addrb <= addrb;
         cap_dinb  <= dinb;
      end
   end

   logic [7:0] ref_b [4*DEPTH] = '{default: '0};
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
      logic e;
      e = (sz == 2'b11) || ((a >> 2) >= DEPTH);
`ifdef BRAM_DMEM_MASTER_MISALIGN_CHECK_EN
      if ((sz == 2'b01) && a[0]) e = 1'b1;
      if ((sz == 2'b10) && (a[1:0] != 2'b00)) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
      int unsigned nb, base;
      logic [31:0] v;
      nb   = 1 << sz;
      base = a & ~(nb - 1);
      v    = '0;
      for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = ref_b[base + i];
      if (!uns && (nb < 4) && v[8*nb - 1])
         for (int unsigned i = 8*nb; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int unsigned nb, base;
      nb   = 1 << sz;
      base = a & ~(nb - 1);
      for (int unsigned i = 0; i < nb; i++) ref_b[base + i] = wd[8*i +: 8];
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "/req_ready"}, 32'(req_ready), 0);
      chk({nm, "/rsp_valid"}, 32'(rsp_valid), 0);
      chk({nm, "/rsp_rdata"}, rsp_rdata, 0);
      chk({nm, "/rsp_err"},   32'(rsp_err), 0);
      chk({nm, "/enb"},       32'(enb), 0);
      chk({nm, "/web"},       32'(web), 0);
      chk({nm, "/addrb"},     addrb, 0);
      chk({nm, "/dinb"},      dinb, 0);
   endtask

   // Starts and ends at a negedge with the DUT idle.
   task automatic txn(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int hold, input logic busy_mid,
                      input logic x_err, input logic [31:0] x_rd, input logic chk_lanes,
                      input logic [3:0] x_web, input logic [31:0] x_dinb);
      int lat, e0;
      e0 = enb_total;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      rsp_ready = (hold == 0);
      lat = 0;
      while (!req_ready && lat < 20) begin @(negedge clkb); lat++; end
      if (!req_ready) begin
         chk({nm, "/accept_timeout"}, 0, 1);
         req_valid = 1'b0;
         return;
      end
      if (we && !model_err(sz, a)) model_store(sz, a, wd);
      @(posedge clkb);
      @(negedge clkb);
      req_valid = 1'b0;
      if (busy_mid) rstb_busy = 1'b1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin @(negedge clkb); lat++; end
      chk({nm, "/latency"}, 32'(lat), x_err ? 0 : (we ? 1 : 2));
      chk({nm, "/rsp_err"}, 32'(rsp_err), 32'(x_err));
      chk({nm, "/rsp_rdata"}, rsp_rdata, x_rd);
      chk({nm, "/enb_cycles"}, 32'(enb_total - e0), x_err ? 0 : 1);
      if (!x_err) chk({nm, "/addrb"}, cap_addrb, {a[31:2], 2'b00});
      if (chk_lanes && !x_err) begin
         chk({nm, "/web"}, 32'(cap_web), 32'(x_web));
         chk({nm, "/dinb"}, cap_dinb, x_dinb);
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clkb);
         chk({nm, "/hold_valid"}, 32'(rsp_valid), 1);
         chk({nm, "/hold_rdata"}, rsp_rdata, x_rd);
         chk({nm, "/hold_ready"}, 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clkb);
      @(negedge clkb);
      chk({nm, "/valid_drop"}, 32'(rsp_valid), 0);
      if (busy_mid) begin
         chk({nm, "/busy_blocks"}, 32'(req_ready), 0);
         rstb_busy = 1'b0;
         @(negedge clkb);
      end
   endtask

   typedef struct {
      logic we; logic [1:0] sz; logic uns; logic [31:0] a; logic [31:0] wd; int hold;
      logic err; logic [31:0] rd; logic [3:0] web; logic [31:0] dinb;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF});
      tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        5, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'h0000007F, 0, 1'b0, 32'h0,        4'h8, 32'h7F7F7F7F});
      tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        0, 1'b0, 32'h0000007F, 4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, 0, 1'b0, 32'h0,        4'h8, 32'h80808080});
      tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        0, 1'b0, 32'hFFFF80AD, 4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'hBEEF1234, 0, 1'b0, 32'h0,        4'hF, 32'hBEEF1234});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        0, 1'b0, 32'h0000BEEF, 4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        2, 1'b0, 32'hFFFFBEEF, 4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        0, 1'b0, 32'hFFFFFFBE, 4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        0, 1'b0, 32'h00000012, 4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h20, 32'hA5A55A5A, 0, 1'b0, 32'h0,        4'h3, 32'h5A5A5A5A});
      tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        0, 1'b0, 32'hBEEF5A5A, 4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        0, 1'b1, 32'h0,        4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 3, 1'b1, 32'h0,       4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFC, 32'h80000001, 0, 1'b0, 32'h0,        4'hF, 32'h80000001});
      tbl.push_back('{1'b0, 2'd0, 1'b0, 32'hFF, 32'h0,        0, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0});
`ifdef BRAM_DMEM_MASTER_MISALIGN_CHECK_EN
      tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        0, 1'b1, 32'h0,        4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        0, 1'b1, 32'h0,        4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'h1234,     0, 1'b1, 32'h0,        4'h0, 32'h0});
`else
      tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        0, 1'b0, 32'h80ADBEEF, 4'h0, 32'h0});
      tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        0, 1'b0, 32'hFFFF80AD, 4'h0, 32'h0});
      tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'h1234,     0, 1'b0, 32'h0,        4'h3, 32'h12341234});
`endif

      // Reset state.
      @(negedge clkb);
      chk_reset_outputs("reset");
      @(negedge clkb);
      rstb = 1'b0;
      @(negedge clkb);
      chk("post_reset_ready", 32'(req_ready), 1);

      for (int i = 0; i < tbl.size(); i++) begin
         txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
             tbl[i].hold, 1'b0, tbl[i].err, tbl[i].rd, 1'b1, tbl[i].web, tbl[i].dinb);
         if (i == 0) chk("vec0/mem_word4", mem[4], 32'hDEADBEEF);
      end

      // rstb_busy in IDLE blocks acceptance.
      begin
         int e0;
         e0 = enb_total;
         rstb_busy = 1'b1;
         req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
         for (int k = 0; k < 3; k++) begin
            @(negedge clkb);
            chk("busy_idle/req_ready", 32'(req_ready), 0);
            chk("busy_idle/rsp_valid", 32'(rsp_valid), 0);
         end
         req_valid = 1'b0;
         @(negedge clkb);
         chk("busy_idle/no_enb", 32'(enb_total - e0), 0);
         rstb_busy = 1'b0;
         @(negedge clkb);
      end

      // rstb_busy rising mid-transaction does not abort it.
      txn("busy_mid", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, 1'b1, 1'b0, model_load(2'd2, 1'b0, 32'h20),
          1'b0, 4'h0, 32'h0);

      // Reset asserted during DATA drops the transaction.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; rsp_ready = 1'b1;
      @(posedge clkb);
      @(negedge clkb);
      req_valid = 1'b0;
      @(negedge clkb);
      rstb = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge clkb);
      rstb = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clkb);
         chk("rst_mid/no_rsp", 32'(rsp_valid), 0);
         chk("rst_mid/ready", 32'(req_ready), 1);
      end
      txn("after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, model_load(2'd2, 1'b0, 32'h10),
          1'b0, 4'h0, 32'h0);

      // Randomized traffic against the byte-array model.
      for (int k = 0; k < 200; k++) begin
         logic        we, uns, e;
         logic [1:0]  sz;
         logic [31:0] a, wd, rd;
         int          hold;
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
         wd   = $urandom;
         hold = $urandom_range(0, 2);
         e    = model_err(sz, a);
         rd   = (e || we) ? 32'h0 : model_load(sz, uns, a);
         txn("rnd", we, sz, uns, a, wd, hold, 1'b0, e, rd, 1'b0, 4'h0, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
